bp_update_scheduler: RTL and testbench
======================================

// Module: bp_update_scheduler
// PURPOSE
//  Sequences all writes into the BHT/PHT branch predictor, which has one update port.
//  After reset, and on a clear request, it walks every table entry to clear it
//  (BHT to 0, PHT to strongly-not-taken).
//  In normal operation it queues branch resolutions from two retire lanes and issues
//  at most one predictor update per cycle, lane 0 (older) before lane 1.
//  It sits between the retire stage and the predictor's update_* inputs.
// PARAMETERS
//  PHT_IDX_W  7    PHT index width
//  BHT_IDX_W  4    BHT index width
//  PHT_ENTRIES 128 entries walked during init (must be >= 2**BHT_IDX_W)
//  DEPTH      4    update queue depth, power of 2, >= 2
// PORTS
//  clk             in   1          rising-edge clock; the only clock
//  reset           in   1          synchronous, active-high reset
//  ret0_valid      in   1          lane 0 resolved branch (older)
//  ret0_pht_index  in   PHT_IDX_W  lane 0 PHT index carried from fetch
//  ret0_bht_index  in   BHT_IDX_W  lane 0 BHT index carried from fetch
//  ret0_taken      in   1          lane 0 actual outcome
//  ret1_valid/ret1_pht_index/ret1_bht_index/ret1_taken  in  as lane 0, younger lane
//  ret_ready       out  1          both lanes may present this cycle
//  clear_req       in   1          one-cycle pulse: drain queue, then re-init tables
//  upd_en          out  1          write predictor this cycle
//  upd_init        out  1          write is a clear (BHT<=0, PHT<=2'b00); ignore upd_branch_en
//  upd_pht_index   out  PHT_IDX_W  PHT entry to write
//  upd_bht_index   out  BHT_IDX_W  BHT entry to write
//  upd_branch_en   out  1          outcome for FSM/BHR shift
//  init_busy       out  1          tables invalid; fetch must treat the prediction as not-taken
// BEHAVIOUR
//  Reset state (after any edge with reset=1):
//   - state=INIT, init_idx=0, queue empty (rd/wr ptr 0, count 0).
//   - Outputs: upd_en=1, upd_init=1, upd_pht_index=0, upd_bht_index=0, upd_branch_en=0,
//     init_busy=1, ret_ready=0.
//   - init_idx holds at 0 while reset stays high.
//  States:
//   - INIT: upd_en=1, upd_init=1, upd_pht_index=init_idx, upd_bht_index=init_idx[BHT_IDX_W-1:0].
//     init_idx increments each cycle. After index PHT_ENTRIES-1 is written, go to RUN.
//     Exactly PHT_ENTRIES writes follow reset release.
//   - RUN: ret_ready = (count <= DEPTH-2), derived from registers only and independent of
//     the valid inputs. Head of queue is driven to upd_*: upd_en = (count!=0), upd_init=0.
//     clear_req=1 -> DRAIN next cycle; lanes presented in that same cycle are still accepted
//     if ret_ready=1.
//   - DRAIN: ret_ready=0; keep emitting until count==0; then go to INIT with init_idx=0.
//  Enqueue (valid && ret_ready):
//   - Lane 0 is written before lane 1. If only one lane is valid, it takes a single slot.
//   - Valid with ret_ready=0 is ignored; retire holds it.
//  Dequeue: one entry per cycle when upd_en=1 and upd_init=0.
//  Occupancy: count_next = count + enq_n - deq. The count register is clog2(DEPTH+1) bits wide.
//   Pointers wrap modulo DEPTH.
//  Latency: an entry accepted at edge N appears on upd_* in cycle N+1 if the queue was empty.
//  Ordering: strict FIFO. No merging of identical indices.
//  clear_req in INIT or DRAIN is ignored (not queued).
//  Reset mid-operation discards queued entries and restarts INIT at index 0.
//  No overflow or underflow is possible; assert count<=DEPTH in simulation.
// TESTING
//  1 Reset 3 cycles, release -> upd_init=1 for 128 cycles, indices 0..127; then init_busy=0,
//    ret_ready=1, upd_en=0.
//  2 RUN, queue empty: ret0{pht=0x15,bht=3,taken=1} + ret1{pht=0x2A,bht=7,taken=0} in one cycle
//    -> cycle+1 upd {0x15,3,1}, cycle+2 upd {0x2A,7,0}, then upd_en=0.
//  3 Only ret1_valid {pht=0x40,bht=9,taken=1} -> single update next cycle; count returns to 0.
//  4 Both lanes valid every cycle for 20 cycles, DEPTH=4 -> ret_ready low whenever count>2;
//    emitted sequence equals the accepted sequence, no loss or duplication.
//  5 Three entries queued, clear_req pulse -> ret_ready=0 next cycle; 3 updates emitted,
//    then 128 init writes from index 0, then RUN.
//  6 reset asserted during DRAIN with 2 queued -> queued entries are never emitted;
//    INIT restarts at 0; clear_req during INIT has no effect.

Source files
------------

// File: rtl/bp_update_scheduler.sv
// Single-port update sequencer for the BHT/PHT branch predictor.
// Walks all entries to clear them after reset/clear, then issues queued retire updates in order.
module bp_update_scheduler #(
    parameter int PHT_IDX_W   = 7,
    parameter int BHT_IDX_W   = 4,
    parameter int PHT_ENTRIES = 128,
    parameter int DEPTH       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ret0_valid,
    input  logic [PHT_IDX_W-1:0] ret0_pht_index,
    input  logic [BHT_IDX_W-1:0] ret0_bht_index,
    input  logic                 ret0_taken,
    input  logic                 ret1_valid,
    input  logic [PHT_IDX_W-1:0] ret1_pht_index,
    input  logic [BHT_IDX_W-1:0] ret1_bht_index,
    input  logic                 ret1_taken,
    output logic                 ret_ready,
    input  logic                 clear_req,
    output logic                 upd_en,
    output logic                 upd_init,
    output logic [PHT_IDX_W-1:0] upd_pht_index,
    output logic [BHT_IDX_W-1:0] upd_bht_index,
    output logic                 upd_branch_en,
    output logic                 init_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PHT_IDX_W-1:0] pht;
        logic [BHT_IDX_W-1:0] bht;
        logic                 taken;
    } entry_t;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t               state;
    logic [PHT_IDX_W-1:0] init_idx;
    entry_t               mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;

    logic             enq0;
    logic             enq1;
    logic             deq;
    logic             last_idx;
    logic [PTR_W-1:0] wr_ptr1;
    logic [CNT_W-1:0] enq_n;
    entry_t           head;

    // Two free slots are required so both lanes can always be taken together
    assign ret_ready = (state == S_RUN) && (count <= CNT_W'(DEPTH - 2));
    assign enq0      = ret0_valid && ret_ready;
    assign enq1      = ret1_valid && ret_ready;
    assign enq_n     = CNT_W'(enq0) + CNT_W'(enq1);
    assign wr_ptr1   = wr_ptr + PTR_W'(enq0);
    assign deq       = (state != S_INIT) && (count != '0);
    assign head      = mem[rd_ptr];
    assign last_idx  = init_idx == PHT_IDX_W'(PHT_ENTRIES - 1);
    assign init_busy = state == S_INIT;

    always_comb begin
        upd_en        = 1'b0;
        upd_init      = 1'b0;
        upd_pht_index = head.pht;
        upd_bht_index = head.bht;
        upd_branch_en = 1'b0;
        if (state == S_INIT) begin
            upd_en        = 1'b1;
            upd_init      = 1'b1;
            upd_pht_index = init_idx;
            upd_bht_index = init_idx[BHT_IDX_W-1:0];
        end else begin
            upd_en        = count != '0;
            upd_branch_en = head.taken;
        end
    end

    always_ff @(posedge clk) begin
        if (enq0) begin
            mem[wr_ptr] <= '{ret0_pht_index, ret0_bht_index, ret0_taken};
        end
        if (enq1) begin
            mem[wr_ptr1] <= '{ret1_pht_index, ret1_bht_index, ret1_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_INIT;
            init_idx <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(enq_n);
            rd_ptr <= rd_ptr + PTR_W'(deq);
            count  <= count + enq_n - CNT_W'(deq);
            unique case (state)
                S_INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (last_idx) begin
                        state    <= S_RUN;
                        init_idx <= '0;
                    end
                end
                S_RUN: begin
                    if (clear_req) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (count == '0) state <= S_INIT;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset) count <= CNT_W'(DEPTH)
    );

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler with a queue-based reference model.
// Model is checked every cycle; literal expectations pin the directed scenarios.
module tb_bp_update_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       ret0_valid, ret0_taken, ret1_valid, ret1_taken;
    logic [6:0] ret0_pht_index, ret1_pht_index;
    logic [3:0] ret0_bht_index, ret1_bht_index;
    logic       ret_ready, clear_req;
    logic       upd_en, upd_init, upd_branch_en, init_busy;
    logic [6:0] upd_pht_index;
    logic [3:0] upd_bht_index;

    int checks = 0;
    int errors = 0;

    bp_update_scheduler dut (
        .clk(clk), .reset(reset),
        .ret0_valid(ret0_valid), .ret0_pht_index(ret0_pht_index),
        .ret0_bht_index(ret0_bht_index), .ret0_taken(ret0_taken),
        .ret1_valid(ret1_valid), .ret1_pht_index(ret1_pht_index),
        .ret1_bht_index(ret1_bht_index), .ret1_taken(ret1_taken),
        .ret_ready(ret_ready), .clear_req(clear_req),
        .upd_en(upd_en), .upd_init(upd_init),
        .upd_pht_index(upd_pht_index), .upd_bht_index(upd_bht_index),
        .upd_branch_en(upd_branch_en), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = clearing tables, 1 = running, 2 = draining
    typedef struct packed {
        logic [6:0] pht;
        logic [3:0] bht;
        logic       tk;
    } ent_t;

    ent_t m_q[$];
    int   m_mode = 0;
    int   m_idx  = 0;
    bit   m_live = 0;
    int   emitted = 0;

    always @(posedge clk) begin
        int sz;
        if (reset) begin
            m_live = 1;
            m_mode = 0;
            m_idx  = 0;
            m_q.delete();
        end else if (m_live) begin
            sz = m_q.size();
            if (m_mode == 0) begin
                m_idx = m_idx + 1;
                if (m_idx == 128) begin
                    m_mode = 1;
                    m_idx  = 0;
                end
            end else begin
                if (sz > 0) void'(m_q.pop_front());
                if (m_mode == 1 && sz <= 2) begin
                    if (ret0_valid) m_q.push_back({ret0_pht_index, ret0_bht_index, ret0_taken});
                    if (ret1_valid) m_q.push_back({ret1_pht_index, ret1_bht_index, ret1_taken});
                end
                if (m_mode == 1 && clear_req) m_mode = 2;
                else if (m_mode == 2 && sz == 0) m_mode = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            if (m_mode == 0) begin
                chk("init_en", int'(upd_en), 1);
                chk("init_flag", int'(upd_init), 1);
                chk("init_pht", int'(upd_pht_index), m_idx);
                chk("init_bht", int'(upd_bht_index), m_idx % 16);
                chk("init_busy", int'(init_busy), 1);
                chk("init_rdy", int'(ret_ready), 0);
            end else begin
                chk("run_en", int'(upd_en), int'(m_q.size() != 0));
                chk("run_flag", int'(upd_init), 0);
                chk("run_busy", int'(init_busy), 0);
                chk("run_rdy", int'(ret_ready), int'(m_mode == 1 && m_q.size() <= 2));
                if (m_q.size() != 0) begin
                    chk("run_pht", int'(upd_pht_index), int'(m_q[0].pht));
                    chk("run_bht", int'(upd_bht_index), int'(m_q[0].bht));
                    chk("run_tk", int'(upd_branch_en), int'(m_q[0].tk));
                end
                if (upd_en && !upd_init) emitted++;
            end
        end
    end

    task automatic lanes(input logic v0, input logic [6:0] p0, input logic [3:0] b0,
                         input logic t0, input logic v1, input logic [6:0] p1,
                         input logic [3:0] b1, input logic t1);
        ret0_valid = v0; ret0_pht_index = p0; ret0_bht_index = b0; ret0_taken = t0;
        ret1_valid = v1; ret1_pht_index = p1; ret1_bht_index = b1; ret1_taken = t1;
    endtask

    task automatic idle();
        lanes(1'b0, 7'h0, 4'h0, 1'b0, 1'b0, 7'h0, 4'h0, 1'b0);
    endtask

    // Samples from the current negedge until init ends; optional clear pulse mid-walk
    task automatic count_init(input int pulse_at, output int n, output int first, output int last);
        n = 0; first = -1; last = -1;
        for (int k = 0; k < 400; k++) begin
            if (!init_busy) break;
            clear_req = (k == pulse_at);
            if (upd_en && upd_init) begin
                if (n == 0) first = int'(upd_pht_index);
                last = int'(upd_pht_index);
                n++;
            end
            @(negedge clk);
        end
        clear_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && upd_en; k++) @(negedge clk);
        chk("idle_timeout", int'(upd_en), 0);
    endtask

    initial begin
        int n, first, last, r, e0, nemit;
        reset = 1'b1;
        clear_req = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_reset_busy", int'(init_busy), 1);
        chk("t1_reset_rdy", int'(ret_ready), 0);
        reset = 1'b0;

        count_init(-1, n, first, last);
        chk("t1_init_n", n, 128);
        chk("t1_init_first", first, 0);
        chk("t1_init_last", last, 127);
        chk("t1_rdy", int'(ret_ready), 1);
        chk("t1_en", int'(upd_en), 0);

        lanes(1'b1, 7'h15, 4'd3, 1'b1, 1'b1, 7'h2A, 4'd7, 1'b0);
        @(negedge clk); idle();
        chk("t2_en0", int'(upd_en), 1);
        chk("t2_pht0", int'(upd_pht_index), 'h15);
        chk("t2_bht0", int'(upd_bht_index), 3);
        chk("t2_tk0", int'(upd_branch_en), 1);
        @(negedge clk);
        chk("t2_pht1", int'(upd_pht_index), 'h2A);
        chk("t2_bht1", int'(upd_bht_index), 7);
        chk("t2_tk1", int'(upd_branch_en), 0);
        @(negedge clk);
        chk("t2_done", int'(upd_en), 0);

        lanes(1'b0, 7'h0, 4'h0, 1'b0, 1'b1, 7'h40, 4'd9, 1'b1);
        @(negedge clk); idle();
        chk("t3_en", int'(upd_en), 1);
        chk("t3_pht", int'(upd_pht_index), 'h40);
        chk("t3_bht", int'(upd_bht_index), 9);
        @(negedge clk);
        chk("t3_done", int'(upd_en), 0);

        e0 = emitted; r = 0;
        for (int k = 0; k < 20; k++) begin
            lanes(1'b1, 7'(2 * k), 4'(k), 1'(k), 1'b1, 7'(2 * k + 1), 4'(k + 8), 1'(k + 1));
            if (ret_ready) r++;
            @(negedge clk);
        end
        idle();
        wait_idle();
        chk("t4_ready_cycles", r, 11);
        chk("t4_emitted", emitted - e0, 22);

        lanes(1'b1, 7'h11, 4'd1, 1'b1, 1'b1, 7'h12, 4'd2, 1'b0);
        @(negedge clk);
        lanes(1'b1, 7'h13, 4'd3, 1'b1, 1'b1, 7'h14, 4'd4, 1'b0);
        @(negedge clk); idle();
        clear_req = 1'b1;
        nemit = int'(upd_en);
        @(negedge clk); clear_req = 1'b0;
        chk("t5_rdy_after_clear", int'(ret_ready), 0);
        for (int k = 0; k < 20 && !upd_init; k++) begin
            nemit += int'(upd_en);
            @(negedge clk);
        end
        chk("t5_emitted", nemit, 3);
        count_init(-1, n, first, last);
        chk("t5_init_n", n, 128);
        chk("t5_init_first", first, 0);
        chk("t5_rdy", int'(ret_ready), 1);

        lanes(1'b1, 7'h21, 4'd5, 1'b1, 1'b1, 7'h22, 4'd6, 1'b1);
        @(negedge clk);
        lanes(1'b1, 7'h23, 4'd7, 1'b0, 1'b1, 7'h24, 4'd8, 1'b1);
        @(negedge clk); idle();
        clear_req = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        chk("t6_draining", int'(ret_ready), 0);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        count_init(10, n, first, last);
        chk("t6_init_n", n, 128);
        chk("t6_init_first", first, 0);
        chk("t6_init_last", last, 127);
        repeat (3) begin
            chk("t6_run_rdy", int'(ret_ready), 1);
            chk("t6_run_en", int'(upd_en), 0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
